// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline sequencer for IF_ID / ID_EX / EX_MEM / MEM_WB and the PC.
// Handles load-use bubbles, taken-branch flushes and data-memory freezes.
// A memory access that never completes sets a sticky error.
// Enable encoding on all pipe registers: 0 = capture, 1 = hold.
module pipeline_hazard_ctrl #(
    parameter int unsigned REG_W       = 5,
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic [REG_W-1:0] ex_rt,
    input  logic             ex_mem_rd,
    input  logic             mem_req,
    input  logic             mem_ready,
    input  logic             branch_taken,
    output logic             pc_hold,
    output logic             IF_ID_enable,
    output logic             ID_EX_enable,
    output logic             EX_MEM_enable,
    output logic             MEM_WB_enable,
    output logic             ID_EX_bubble,
    output logic             IF_ID_flush,
    output logic [CNT_W-1:0] stall_cnt,
    output logic             mem_err
);

    localparam int unsigned WAIT_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    typedef enum logic [1:0] {
        RUN,
        MEMWAIT,
        ERR
    } state_t;

    state_t            state;
    logic              run_ok;
    logic [WAIT_W-1:0] wait_cnt;
    logic              load_use;
    logic              mem_stall;
    logic              frozen;

    assign load_use  = ex_mem_rd && (ex_rt != '0) && ((ex_rt == id_rs) || (ex_rt == id_rt));
    assign mem_stall = mem_req && !mem_ready;
    assign frozen    = !run_ok || (state == ERR) || mem_stall;

    // Memory-wait sequencer: tracks consecutive wait cycles and latches the timeout error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= RUN;
            run_ok   <= 1'b0;
            wait_cnt <= '0;
            mem_err  <= 1'b0;
        end else begin
            run_ok <= 1'b1;
            if (run_ok) begin
                unique case (state)
                    RUN: begin
                        if (mem_stall) begin
                            state    <= MEMWAIT;
                            wait_cnt <= WAIT_W'(1);
                        end
                    end
                    MEMWAIT: begin
                        if (mem_ready) begin
                            state    <= RUN;
                            wait_cnt <= '0;
                        end else if (wait_cnt == WAIT_LAST) begin
                            state   <= ERR;
                            mem_err <= 1'b1;
                        end else begin
                            wait_cnt <= wait_cnt + WAIT_W'(1);
                        end
                    end
                    ERR: begin
                        mem_err <= 1'b1;
                    end
                    default: begin
                        state <= ERR;
                    end
                endcase
            end
        end
    end

    // Output decode by priority: freeze > branch flush > load-use bubble > normal flow.
    always_comb begin
        pc_hold       = 1'b0;
        IF_ID_enable  = 1'b0;
        ID_EX_enable  = 1'b0;
        EX_MEM_enable = 1'b0;
        MEM_WB_enable = 1'b0;
        ID_EX_bubble  = 1'b0;
        IF_ID_flush   = 1'b0;
        if (frozen) begin
            pc_hold       = 1'b1;
            IF_ID_enable  = 1'b1;
            ID_EX_enable  = 1'b1;
            EX_MEM_enable = 1'b1;
            MEM_WB_enable = 1'b1;
        end else if (branch_taken) begin
            IF_ID_flush  = 1'b1;
            ID_EX_bubble = 1'b1;
        end else if (load_use) begin
            pc_hold      = 1'b1;
            IF_ID_enable = 1'b1;
            ID_EX_bubble = 1'b1;
        end
    end

    // Saturating count of cycles in which the PC was held after start-up.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (run_ok && pc_hold && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

endmodule
